// File: rtl/uart_cmd_parser.sv
// uart_cmd_parser: turns 3-byte UART frames (opcode, address, data) into
// register bank writes/reads and returns read data through the UART
// transmitter. Malformed, stalled, overrun and out-of-range frames pulse
// cmd_err_o and are counted in a saturating 8-bit error counter.
module uart_cmd_parser #(
   parameter int         NREGS       = 16,
   parameter int         TIMEOUT_CYC = 200000,
   parameter logic [7:0] OP_WR       = 8'h01,
   parameter logic [7:0] OP_RD       = 8'h02
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] rx_data_i,
   input  logic       rx_done_i,
   output logic [7:0] tx_data_o,
   output logic       tx_wr_o,
   input  logic       tx_done_i,
   output logic       reg_wr_o,
   output logic       reg_rd_o,
   output logic [7:0] reg_addr_o,
   output logic [7:0] reg_wdata_o,
   input  logic [7:0] reg_rdata_i,
   output logic       busy_o,
   output logic       cmd_err_o,
   output logic [7:0] err_cnt_o
);

   localparam int            TW       = $clog2(TIMEOUT_CYC + 1);
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);
   // One extra bit so NREGS = 256 still compares correctly.
   localparam logic [8:0]    NREGS_W  = 9'(NREGS);

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      GOT_OP   = 3'd1,
      GOT_ADDR = 3'd2,
      EXEC     = 3'd3,
      RD_WAIT  = 3'd4,
      TX_WAIT  = 3'd5
   } state_t;

   state_t        state_r;
   logic [7:0]    op_r;
   logic [7:0]    addr_r;
   logic [7:0]    data_r;
   logic [TW-1:0] tmo_cnt_r;
   logic          addr_bad_s;

   // Out-of-range address detection for the frame being executed.
   always_comb begin
      addr_bad_s = 1'b0;
      if ({1'b0, addr_r} >= NREGS_W) begin
         addr_bad_s = 1'b1;
      end else begin
         addr_bad_s = 1'b0;
      end
   end

   // Frame FSM with registered strobes, bus outputs and inter-byte timeout.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= IDLE;
         op_r        <= 8'h00;
         addr_r      <= 8'h00;
         data_r      <= 8'h00;
         tmo_cnt_r   <= '0;
         tx_data_o   <= 8'h00;
         tx_wr_o     <= 1'b0;
         reg_wr_o    <= 1'b0;
         reg_rd_o    <= 1'b0;
         reg_addr_o  <= 8'h00;
         reg_wdata_o <= 8'h00;
         busy_o      <= 1'b0;
         cmd_err_o   <= 1'b0;
      end else begin
         reg_wr_o  <= 1'b0;
         reg_rd_o  <= 1'b0;
         tx_wr_o   <= 1'b0;
         cmd_err_o <= 1'b0;
         case (state_r)
            IDLE: begin
               tmo_cnt_r <= '0;
               if (rx_done_i) begin
                  if ((rx_data_i == OP_WR) || (rx_data_i == OP_RD)) begin
                     op_r    <= rx_data_i;
                     state_r <= GOT_OP;
                     busy_o  <= 1'b1;
                  end else begin
                     cmd_err_o <= 1'b1;
                  end
               end
            end
            GOT_OP: begin
               // A byte arriving in the expiry cycle wins over the timeout.
               if (rx_done_i) begin
                  addr_r    <= rx_data_i;
                  tmo_cnt_r <= '0;
                  state_r   <= GOT_ADDR;
               end else if (tmo_cnt_r == TMO_LAST) begin
                  tmo_cnt_r <= '0;
                  cmd_err_o <= 1'b1;
                  busy_o    <= 1'b0;
                  state_r   <= IDLE;
               end else begin
                  tmo_cnt_r <= tmo_cnt_r + TW'(1);
               end
            end
            GOT_ADDR: begin
               if (rx_done_i) begin
                  data_r    <= rx_data_i;
                  tmo_cnt_r <= '0;
                  state_r   <= EXEC;
               end else if (tmo_cnt_r == TMO_LAST) begin
                  tmo_cnt_r <= '0;
                  cmd_err_o <= 1'b1;
                  busy_o    <= 1'b0;
                  state_r   <= IDLE;
               end else begin
                  tmo_cnt_r <= tmo_cnt_r + TW'(1);
               end
            end
            EXEC: begin
               if (rx_done_i || addr_bad_s) begin
                  cmd_err_o <= 1'b1;
               end
               if (addr_bad_s) begin
                  busy_o  <= 1'b0;
                  state_r <= IDLE;
               end else if (op_r == OP_WR) begin
                  reg_wr_o    <= 1'b1;
                  reg_addr_o  <= addr_r;
                  reg_wdata_o <= data_r;
                  busy_o      <= 1'b0;
                  state_r     <= IDLE;
               end else begin
                  reg_rd_o   <= 1'b1;
                  reg_addr_o <= addr_r;
                  state_r    <= RD_WAIT;
               end
            end
            RD_WAIT: begin
               if (rx_done_i) begin
                  cmd_err_o <= 1'b1;
               end
               // Read data lands one cycle after the strobe, so the capture
               // waits until the strobe cycle has passed.
               if (!reg_rd_o) begin
                  tx_data_o <= reg_rdata_i;
                  tx_wr_o   <= 1'b1;
                  state_r   <= TX_WAIT;
               end
            end
            TX_WAIT: begin
               if (rx_done_i) begin
                  cmd_err_o <= 1'b1;
               end
               if (tx_done_i) begin
                  busy_o  <= 1'b0;
                  state_r <= IDLE;
               end
            end
            default: begin
               busy_o  <= 1'b0;
               state_r <= IDLE;
            end
         endcase
      end
   end

   // Saturating count of error pulses.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_cnt_o <= 8'h00;
      end else if (cmd_err_o && (err_cnt_o != 8'hFF)) begin
         err_cnt_o <= err_cnt_o + 8'h01;
      end
   end

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Directed bench for uart_cmd_parser: frame table plus hand sequences for
// latency, bad opcode, timeout, overrun, async reset and error saturation.
module tb_uart_cmd_parser;

   localparam int TMO = 20;
   localparam int TXD = 4;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] rx_data_i = 8'h00;
   logic       rx_done_i = 1'b0;
   logic [7:0] tx_data_o;
   logic       tx_wr_o;
   logic       tx_done_i = 1'b0;
   logic       reg_wr_o, reg_rd_o;
   logic [7:0] reg_addr_o, reg_wdata_o;
   logic [7:0] reg_rdata_i = 8'h00;
   logic       busy_o, cmd_err_o;
   logic [7:0] err_cnt_o;

   uart_cmd_parser #(.NREGS(16), .TIMEOUT_CYC(TMO)) dut (
      .clk(clk), .rst_n(rst_n),
      .rx_data_i(rx_data_i), .rx_done_i(rx_done_i),
      .tx_data_o(tx_data_o), .tx_wr_o(tx_wr_o), .tx_done_i(tx_done_i),
      .reg_wr_o(reg_wr_o), .reg_rd_o(reg_rd_o),
      .reg_addr_o(reg_addr_o), .reg_wdata_o(reg_wdata_o),
      .reg_rdata_i(reg_rdata_i),
      .busy_o(busy_o), .cmd_err_o(cmd_err_o), .err_cnt_o(err_cnt_o)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // register bank model
   logic [7:0] mem [16];
   initial for (int i = 0; i < 16; i++) mem[i] = 8'h00;
   always @(posedge clk) begin
      if (reg_wr_o) mem[reg_addr_o[3:0]] <= reg_wdata_o;
      if (reg_rd_o) reg_rdata_i <= mem[reg_addr_o[3:0]];
   end

   // UART transmitter model
   logic       tx_busy = 1'b0;
   int         tx_dly = 0;
   logic [7:0] uart_byte = 8'h00;
   always @(posedge clk) begin
      tx_done_i <= 1'b0;
      if (tx_busy) begin
         if (tx_dly == 0) begin
            tx_done_i <= 1'b1;
            tx_busy   <= 1'b0;
            uart_byte <= tx_data_o;
         end else begin
            tx_dly <= tx_dly - 1;
         end
      end else if (tx_wr_o) begin
         tx_busy <= 1'b1;
         tx_dly  <= TXD;
      end
   end

   // pulse monitors
   int n_wr = 0, n_rd = 0, n_tx = 0, n_err = 0, dbl = 0;
   int wr_cyc = 0, rd_cyc = 0, tx_cyc = 0;
   logic [7:0] last_wa = 8'h00, last_wd = 8'h00, last_txb = 8'h00;
   logic p_wr = 1'b0, p_rd = 1'b0, p_tx = 1'b0, p_err = 1'b0;
   always @(negedge clk) begin
      if (reg_wr_o) begin n_wr <= n_wr + 1; wr_cyc <= cyc; last_wa <= reg_addr_o; last_wd <= reg_wdata_o; end
      if (reg_rd_o) begin n_rd <= n_rd + 1; rd_cyc <= cyc; end
      if (tx_wr_o) begin n_tx <= n_tx + 1; tx_cyc <= cyc; last_txb <= tx_data_o; end
      if (cmd_err_o) n_err <= n_err + 1;
      if ((reg_wr_o && p_wr) || (reg_rd_o && p_rd) || (tx_wr_o && p_tx) || (cmd_err_o && p_err))
         dbl <= dbl + 1;
      p_wr <= reg_wr_o; p_rd <= reg_rd_o; p_tx <= tx_wr_o; p_err <= cmd_err_o;
   end

   int n_vec = 0, n_bad = 0;
   int exp_errs = 0;
   int last_rx_cyc = 0;
   int b_wr, b_rd, b_tx, b_err;

   task automatic chk(input string nm, input int act, input int exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      @(posedge clk); #1;
      rx_data_i = b; rx_done_i = 1'b1; last_rx_cyc = cyc;
      @(posedge clk); #1;
      rx_done_i = 1'b0;
   endtask

   task automatic snap();
      b_wr = n_wr; b_rd = n_rd; b_tx = n_tx; b_err = n_err;
   endtask

   task automatic settle(input int n);
      repeat (n) @(posedge clk);
      @(negedge clk);
   endtask

   typedef struct {
      logic [7:0] op, addr, data;
      int         e_wr, e_rd, e_tx, e_err;
      logic [7:0] e_a, e_d, e_t;
   } vec_t;
   vec_t tbl [8];

   initial begin
      tbl[0] = '{8'h01, 8'h00, 8'hA1, 1, 0, 0, 0, 8'h00, 8'hA1, 8'h00};
      tbl[1] = '{8'h02, 8'h00, 8'h00, 0, 1, 1, 0, 8'h00, 8'h00, 8'hA1};
      tbl[2] = '{8'h01, 8'h03, 8'h55, 1, 0, 0, 0, 8'h03, 8'h55, 8'h00};
      tbl[3] = '{8'h02, 8'h03, 8'h00, 0, 1, 1, 0, 8'h03, 8'h00, 8'h55};
      tbl[4] = '{8'h01, 8'h10, 8'hFF, 0, 0, 0, 1, 8'h00, 8'h00, 8'h00};
      tbl[5] = '{8'h02, 8'h10, 8'h00, 0, 0, 0, 1, 8'h00, 8'h00, 8'h00};
      tbl[6] = '{8'h01, 8'h0F, 8'h3C, 1, 0, 0, 0, 8'h0F, 8'h3C, 8'h00};
      tbl[7] = '{8'h02, 8'h0F, 8'h00, 0, 1, 1, 0, 8'h0F, 8'h00, 8'h3C};

      // reset state
      repeat (3) @(posedge clk);
      #1;
      chk("rst busy", busy_o, 0);
      chk("rst tx_wr", tx_wr_o, 0);
      chk("rst reg_wr", reg_wr_o, 0);
      chk("rst reg_rd", reg_rd_o, 0);
      chk("rst err", cmd_err_o, 0);
      chk("rst err_cnt", err_cnt_o, 0);
      chk("rst addr", reg_addr_o, 0);
      chk("rst tx_data", tx_data_o, 0);
      rst_n = 1'b1;

      // frame table
      for (int i = 0; i < 8; i++) begin
         snap();
         send_byte(tbl[i].op);
         send_byte(tbl[i].addr);
         send_byte(tbl[i].data);
         settle(15);
         exp_errs += tbl[i].e_err;
         chk($sformatf("v%0d wr", i), n_wr - b_wr, tbl[i].e_wr);
         chk($sformatf("v%0d rd", i), n_rd - b_rd, tbl[i].e_rd);
         chk($sformatf("v%0d tx", i), n_tx - b_tx, tbl[i].e_tx);
         chk($sformatf("v%0d err", i), n_err - b_err, tbl[i].e_err);
         chk($sformatf("v%0d err_cnt", i), err_cnt_o, exp_errs);
         chk($sformatf("v%0d busy", i), busy_o, 0);
         if (tbl[i].e_wr != 0) begin
            chk($sformatf("v%0d waddr", i), last_wa, tbl[i].e_a);
            chk($sformatf("v%0d wdata", i), last_wd, tbl[i].e_d);
         end
         if (tbl[i].e_tx != 0) begin
            chk($sformatf("v%0d tx_data", i), last_txb, tbl[i].e_t);
            chk($sformatf("v%0d uart", i), uart_byte, tbl[i].e_t);
         end
      end

      // latency: write 2 cycles after 3rd byte, tx_wr 2 cycles after reg_rd
      send_byte(8'h01); send_byte(8'h02); send_byte(8'h77);
      settle(10);
      chk("wr latency", wr_cyc - last_rx_cyc, 2);
      send_byte(8'h02); send_byte(8'h02); send_byte(8'h00);
      settle(15);
      chk("rd latency", rd_cyc - last_rx_cyc, 2);
      chk("tx latency", tx_cyc - rd_cyc, 2);
      chk("rd data", uart_byte, 8'h77);

      // bad opcode, then a good frame
      snap();
      send_byte(8'h7F);
      send_byte(8'h01); send_byte(8'h03); send_byte(8'h66);
      settle(10);
      exp_errs += 1;
      chk("badop err", n_err - b_err, 1);
      chk("badop err_cnt", err_cnt_o, exp_errs);
      chk("badop next wr", n_wr - b_wr, 1);
      chk("badop next addr", last_wa, 8'h03);
      chk("badop next data", last_wd, 8'h66);

      // timeout discards partial frame
      snap();
      send_byte(8'h01); send_byte(8'h05);
      settle(TMO + 5);
      exp_errs += 1;
      chk("tmo err", n_err - b_err, 1);
      chk("tmo busy", busy_o, 0);
      chk("tmo wr", n_wr - b_wr, 0);
      snap();
      send_byte(8'h02); send_byte(8'h05); send_byte(8'h00);
      settle(15);
      chk("tmo readback", uart_byte, 8'h00);
      chk("tmo readback err", n_err - b_err, 0);

      // byte in the expiry cycle wins
      snap();
      send_byte(8'h01);
      repeat (TMO - 2) @(posedge clk);
      send_byte(8'h06); send_byte(8'h99);
      settle(10);
      chk("tmo edge err", n_err - b_err, 0);
      chk("tmo edge wr", n_wr - b_wr, 1);
      chk("tmo edge data", last_wd, 8'h99);

      // overrun during TX_WAIT
      snap();
      send_byte(8'h02); send_byte(8'h06); send_byte(8'h00);
      repeat (4) @(posedge clk);
      send_byte(8'h01);
      settle(15);
      exp_errs += 1;
      chk("ovr err", n_err - b_err, 1);
      chk("ovr tx", n_tx - b_tx, 1);
      chk("ovr data", uart_byte, 8'h99);
      chk("ovr busy", busy_o, 0);

      // rx and tx_done in the same TX_WAIT cycle
      snap();
      send_byte(8'h02); send_byte(8'h06); send_byte(8'h00);
      repeat (8) @(posedge clk);
      send_byte(8'h02);
      settle(3);
      exp_errs += 1;
      chk("simul err", n_err - b_err, 1);
      chk("simul busy", busy_o, 0);
      chk("simul err_cnt", err_cnt_o, exp_errs);

      // async reset in GOT_ADDR
      snap();
      send_byte(8'h01); send_byte(8'h07);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("arst busy", busy_o, 0);
      chk("arst err_cnt", err_cnt_o, 0);
      chk("arst addr", reg_addr_o, 0);
      chk("arst tx_data", tx_data_o, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      exp_errs = 0;
      settle(TMO + 5);
      chk("arst no wr", n_wr - b_wr, 0);
      chk("arst no rd", n_rd - b_rd, 0);
      chk("arst no tx", n_tx - b_tx, 0);
      chk("arst no err", n_err - b_err, 0);

      // error counter saturation
      snap();
      for (int k = 0; k < 260; k++) send_byte(8'hFF);
      settle(3);
      chk("sat pulses", n_err - b_err, 260);
      chk("sat err_cnt", err_cnt_o, 255);

      chk("strobe width", dbl, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

endmodule
